receivereg2: RTL
================

# receivereg2

Receive data buffer for the CAN controller, the counterpart of the ordinary transmit data register. The receive MAC stores each accepted frame's data bytes and DLC here, and the CPU reads them back through the register bus. Two message slots form a FIFO, so one frame can be received while the CPU is still reading the previous one. Overruns are flagged, and what happens to the overflowing frame is fixed at compile time.

## Interface
- No parameters. Depth is fixed at 2 slots of 64 data bits plus 4-bit DLC.
- clk  in  1  system clock; all state changes on the rising edge
- rst  in  1  synchronous reset, active low
- store  in  1  one-cycle pulse from the receive MAC: frame accepted, capture data_in/dlc_in
- data_in  in  64  received data; byte0 = [63:56] … byte7 = [7:0]
- dlc_in  in  4  received data length code, passed through unmodified
- cpu_addr  in  2  word select within the head slot: 0 = bytes 0/1 (register 0x0e), 1 = bytes 2/3 (0x10), 2 = bytes 4/5 (0x12), 3 = bytes 6/7 (0x14); the lower-numbered byte is in [15:8]
- release  in  1  one-cycle pulse from the CPU: head slot has been read, free it
- clr_ovr  in  1  one-cycle pulse: clear the overrun flag
- regout  out  16  head-slot word selected by cpu_addr, registered
- dlc_out  out  4  DLC of the head slot, registered
- rx_valid  out  1  at least one slot holds an unread frame
- rx_full  out  1  both slots occupied
- overrun  out  1  sticky: a store arrived while rx_full was 1

## Operation
- FIFO states: EMPTY (count 0), ONE (count 1) and FULL (count 2). The block keeps a 1-bit write pointer and a 1-bit read pointer.
- store when not FULL:
  - write data_in/dlc_in into the slot at the write pointer;
  - toggle the write pointer;
  - count + 1.
- release when not EMPTY: toggle the read pointer; count − 1.
- release when EMPTY: ignored; no state change.
- store and release in the same cycle:
  - EMPTY: store only; the result is ONE.
  - ONE: both take effect; count stays 1, and the new frame becomes the head.
  - FULL: release frees the head and store writes the freed slot. Count stays 2 and no overrun is raised.
- store when FULL without release: overrun ← 1. The slot handling depends on RECBUF_OVERWRITE_EN (see Configuration).
- clr_ovr clears overrun. If clr_ovr and an overrunning store occur in the same cycle, the set wins and overrun stays 1.
- Output mapping:
  - rx_valid = (count ≠ 0);
  - rx_full = (count = 2);
  - when count = 0, regout and dlc_out read 0.
- Slot contents are not cleared on release; only the pointers and count change.

## Timing
- Reset (rst = 0 at a clock edge) forces:
  - count to 0 and both pointers to 0;
  - regout = 16'h0000, dlc_out = 4'h0;
  - rx_valid = 0, rx_full = 0, overrun = 0.
  - Slot storage is also cleared to 0.
- Reset overrides store, release and clr_ovr in the same cycle. A frame stored while rst = 0 is lost.
- Store latency:
  - rx_valid, rx_full and overrun update in the cycle after the store edge.
  - regout and dlc_out show the new head one cycle after that, at latency 2. This is because their register samples the updated head slot.
- Read latency: a change of cpu_addr appears on regout one clock later.
- Release latency: the next slot's data appears on regout 2 cycles after the release pulse. rx_valid and rx_full update 1 cycle after it.
- Pulses longer than one cycle act once per cycle they are high. Pulse generation is the caller's responsibility.

## Configuration
- RECBUF_OVERWRITE_EN defined: a store while FULL (no release) overwrites the newest slot, the one at write pointer − 1. The pointers and count are unchanged and overrun is set. The CPU always sees the latest frame as the second entry.
- Undefined (default): a store while FULL is discarded. Both slots keep their contents and overrun is set.

## Structure
- Shared CAN package holds:
  - the word-address constants RX_W0..RX_W3 = 2'd0..2'd3;
  - the register-bus addresses 0x0e/0x10/0x12/0x14;
  - the slot-count encodings EMPTY/ONE/FULL.
- One sub-module, recbuf_slot: a 68-bit slot register with synchronous clear and write enable. It is instantiated twice. Word muxing and FIFO control stay in receivereg2.

## Test plan
- Reset then idle:
  - regout = 0, dlc_out = 0, rx_valid = 0, overrun = 0;
  - release while EMPTY leaves the state unchanged.
- Single frame:
  - stimulus: store with data_in = 64'h0123_4567_89AB_CDEF, dlc_in = 8, then cpu_addr stepped 0..3;
  - required response: regout = 0123, 4567, 89AB, CDEF, each one cycle after its address, and dlc_out = 8;
  - after release: rx_valid = 0 and regout = 0.
- Two frames:
  - stimulus: store A (…AAAA, dlc 2), store B (…BBBB, dlc 3), then release;
  - required response: rx_full = 1 while both are held, A is read first, B is head after the release, and rx_full = 0.
- Overrun, default build:
  - stimulus: FULL with A/B, then store C;
  - required response: overrun = 1, and A then B are read back;
  - after clr_ovr: overrun = 0.
- Overrun with RECBUF_OVERWRITE_EN:
  - stimulus: the same sequence as the default-build overrun test;
  - required response: A then C are read back, and overrun = 1.
- Simultaneous events:
  - store and release together while FULL: the new frame is accepted and overrun stays 0;
  - clr_ovr together with an overrunning store: overrun = 1;
  - rst = 0 together with a store: everything reads 0 afterwards.

Source files
------------

// File: rtl/receivereg2_pkg.sv
// receivereg2_pkg
// Shared CAN receive-buffer definitions: word-select codes for the head-slot
// read port, the register-bus addresses those words live at, the FIFO
// occupancy encodings and the slot layout helpers.
package receivereg2_pkg;

    // Word select codes on cpu_addr
    localparam logic [1:0] RX_W0 = 2'd0;    // bytes 0/1
    localparam logic [1:0] RX_W1 = 2'd1;    // bytes 2/3
    localparam logic [1:0] RX_W2 = 2'd2;    // bytes 4/5
    localparam logic [1:0] RX_W3 = 2'd3;    // bytes 6/7

    // Register-bus addresses of the four receive data words
    localparam logic [7:0] RX_REG_W0 = 8'h0e;
    localparam logic [7:0] RX_REG_W1 = 8'h10;
    localparam logic [7:0] RX_REG_W2 = 8'h12;
    localparam logic [7:0] RX_REG_W3 = 8'h14;

    // Slot layout: {dlc[3:0], data[63:0]}
    localparam int SLOT_W = 68;

    // FIFO occupancy, also the state of the control FSM
    typedef enum logic [1:0] {
        CNT_EMPTY = 2'd0,
        CNT_ONE   = 2'd1,
        CNT_FULL  = 2'd2
    } rx_cnt_e;

    // Select one 16-bit word of a frame; the lower-numbered byte lands in [15:8]
    function automatic logic [15:0] rx_word_sel(input logic [63:0] data,
                                                input logic [1:0]  addr);
        logic [15:0] w;
        case (addr)
            RX_W0:   w = data[63:48];
            RX_W1:   w = data[47:32];
            RX_W2:   w = data[31:16];
            RX_W3:   w = data[15:0];
            default: w = 16'h0000;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/receivereg2_slot.sv
// recbuf_slot
// One 68-bit message slot ({dlc, data}) of the receive FIFO.
// Ports:
//   i_clk  - system clock
//   i_rst  - synchronous clear, active low
//   i_we   - write enable, loads i_d on the rising edge
//   i_d    - slot contents to write
//   o_q    - current slot contents
module recbuf_slot
    import receivereg2_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_we,
    input  logic [SLOT_W-1:0] i_d,
    output logic [SLOT_W-1:0] o_q
);

    logic [SLOT_W-1:0] r_q;

    // Slot storage: cleared by reset, loaded on write enable, otherwise held
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_q <= {SLOT_W{1'b0}};
        end else if (i_we) begin
            r_q <= i_d;
        end else begin
            r_q <= r_q;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/receivereg2.sv
// receivereg2
// CAN receive data buffer: a two-slot FIFO of {dlc, 64-bit data} written by
// the receive MAC and read word-by-word by the CPU.
//
// Build option: RECBUF_OVERWRITE_EN
//   defined   - a store while full (no release) overwrites the newest slot
//   undefined - a store while full is discarded
//   In both builds such a store sets the sticky overrun flag.
//
// Ports (all synchronous to i_clk; "release" is a reserved word in
// SystemVerilog, so every port carries an i_/o_ prefix):
//   i_clk       - system clock
//   i_rst       - synchronous reset, active low
//   i_store     - frame accepted pulse, captures i_data_in / i_dlc_in
//   i_data_in   - frame data, byte0 = [63:56] ... byte7 = [7:0]
//   i_dlc_in    - data length code, stored unmodified
//   i_cpu_addr  - word select within the head slot (RX_W0..RX_W3)
//   i_release   - CPU has read the head slot, free it
//   i_clr_ovr   - clear the overrun flag
//   o_regout    - selected head-slot word, registered
//   o_dlc_out   - head-slot DLC, registered
//   o_rx_valid  - at least one unread frame
//   o_rx_full   - both slots occupied
//   o_overrun   - sticky: a store arrived while full
module receivereg2
    import receivereg2_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_store,
    input  logic [63:0] i_data_in,
    input  logic [3:0]  i_dlc_in,
    input  logic [1:0]  i_cpu_addr,
    input  logic        i_release,
    input  logic        i_clr_ovr,
    output logic [15:0] o_regout,
    output logic [3:0]  o_dlc_out,
    output logic        o_rx_valid,
    output logic        o_rx_full,
    output logic        o_overrun
);

    rx_cnt_e           r_state;
    rx_cnt_e           w_next_state;
    logic              r_wr_ptr;
    logic              r_rd_ptr;
    logic              r_overrun;
    logic [15:0]       r_regout;
    logic [3:0]        r_dlc_out;
    logic              r_rx_valid;
    logic              r_rx_full;

    logic              w_store_acc;   // store that takes a free (or freed) slot
    logic              w_store_ovf;   // store while full with no release
    logic              w_rel_eff;     // release that actually frees a slot
    logic              w_wr_any;
    logic              w_wr_sel;
    logic              w_we0;
    logic              w_we1;
    logic [SLOT_W-1:0] w_slot_d;
    logic [SLOT_W-1:0] w_slot0;
    logic [SLOT_W-1:0] w_slot1;
    logic [SLOT_W-1:0] w_head;

    // Event qualification. A release while full frees the head first, so a
    // simultaneous store is an ordinary accepted store, not an overrun.
    always_comb begin
        w_rel_eff   = i_release && (r_state != CNT_EMPTY);
        w_store_acc = i_store && ((r_state != CNT_FULL) || i_release);
        w_store_ovf = i_store && (r_state == CNT_FULL) && !i_release;
    end

    // Occupancy FSM state register
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state <= CNT_EMPTY;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Occupancy next state; an EMPTY-state release is ignored
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            CNT_EMPTY: begin
                if (i_store) begin
                    w_next_state = CNT_ONE;
                end else begin
                    w_next_state = CNT_EMPTY;
                end
            end
            CNT_ONE: begin
                if (i_store && !i_release) begin
                    w_next_state = CNT_FULL;
                end else if (i_release && !i_store) begin
                    w_next_state = CNT_EMPTY;
                end else begin
                    w_next_state = CNT_ONE;
                end
            end
            CNT_FULL: begin
                if (i_release && !i_store) begin
                    w_next_state = CNT_ONE;
                end else begin
                    w_next_state = CNT_FULL;
                end
            end
            default: begin
                w_next_state = CNT_EMPTY;
            end
        endcase
    end

    // Read/write pointers toggle on each effective release/store
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
        end else begin
            r_wr_ptr <= w_store_acc ? ~r_wr_ptr : r_wr_ptr;
            r_rd_ptr <= w_rel_eff   ? ~r_rd_ptr : r_rd_ptr;
        end
    end

    // Slot write steering. When full with a release, wr_ptr equals rd_ptr, so
    // writing at wr_ptr lands in the slot being freed. An overwriting overrun
    // targets wr_ptr - 1, which for a 1-bit pointer is its complement.
    always_comb begin
        w_wr_any = 1'b0;
        w_wr_sel = r_wr_ptr;
        if (w_store_acc) begin
            w_wr_any = 1'b1;
            w_wr_sel = r_wr_ptr;
`ifdef RECBUF_OVERWRITE_EN
        end else if (w_store_ovf) begin
            w_wr_any = 1'b1;
            w_wr_sel = ~r_wr_ptr;
`endif
        end else begin
            w_wr_any = 1'b0;
            w_wr_sel = r_wr_ptr;
        end
        w_we0    = w_wr_any && !w_wr_sel;
        w_we1    = w_wr_any &&  w_wr_sel;
        w_slot_d = {i_dlc_in, i_data_in};
    end

    recbuf_slot u_slot0 (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_we  (w_we0),
        .i_d   (w_slot_d),
        .o_q   (w_slot0)
    );

    recbuf_slot u_slot1 (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_we  (w_we1),
        .i_d   (w_slot_d),
        .o_q   (w_slot1)
    );

    assign w_head = r_rd_ptr ? w_slot1 : w_slot0;

    // Sticky overrun; a simultaneous overrunning store beats the clear
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_overrun <= 1'b0;
        end else if (w_store_ovf) begin
            r_overrun <= 1'b1;
        end else if (i_clr_ovr) begin
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= r_overrun;
        end
    end

    // Status flags follow the occupancy state into the same edge
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_rx_valid <= 1'b0;
            r_rx_full  <= 1'b0;
        end else begin
            r_rx_valid <= (w_next_state != CNT_EMPTY);
            r_rx_full  <= (w_next_state == CNT_FULL);
        end
    end

    // Read port samples the registered head slot, hence one extra cycle of
    // latency after a store or release compared with the status flags
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_regout  <= 16'h0000;
            r_dlc_out <= 4'h0;
        end else if (r_state == CNT_EMPTY) begin
            r_regout  <= 16'h0000;
            r_dlc_out <= 4'h0;
        end else begin
            r_regout  <= rx_word_sel(w_head[63:0], i_cpu_addr);
            r_dlc_out <= w_head[67:64];
        end
    end

    assign o_regout   = r_regout;
    assign o_dlc_out  = r_dlc_out;
    assign o_rx_valid = r_rx_valid;
    assign o_rx_full  = r_rx_full;
    assign o_overrun  = r_overrun;

endmodule
